kpd_decoder: RTL and testbench

- Keypad decode/debounce stage; sits directly downstream of the column scanner.
- Consumes the scanner's active-low column drive and the raw active-low row inputs from the keypad pins.
- Emits a debounced 4-bit key code with a single-cycle valid strobe per press, plus a held flag.
- Feeds the system logic that consumes keypresses.

---
 rtl/kpd_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_kpd_decoder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kpd_decoder.sv
// Keypad decode/debounce: synchronizes rows and column drive, decodes one key, debounces press and release.
// Optional auto-repeat while a key stays held is enabled by defining KPD_REPEAT_EN.
module kpd_decoder #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] REPEAT_CYCLES   = 32'd25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpc,
    input  logic [3:0] kpr,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned CNT_W = $clog2(int'(DEBOUNCE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    logic [3:0] kpr_s1, kpr_s2;
    logic [3:0] kpc_s1, kpc_s2;

    logic [1:0] row_idx, col_idx;
    logic       row_ok, col_ok;
    logic       dec_valid;
    logic [3:0] dec_key;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]       cand, cand_nxt;
    logic [3:0]       code_nxt;
    logic             valid_nxt, held_nxt;

`ifdef KPD_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(64'(REPEAT_CYCLES) + 64'd1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 32'd1);
    logic [RPT_W-1:0] rpt, rpt_nxt;
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
`endif

    // kpc is delayed alongside kpr so row and column samples refer to the same scan slot
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            kpr_s1 <= 4'hF;
            kpr_s2 <= 4'hF;
            kpc_s1 <= 4'hF;
            kpc_s2 <= 4'hF;
        end else begin
            kpr_s1 <= kpr;
            kpr_s2 <= kpr_s1;
            kpc_s1 <= kpc;
            kpc_s2 <= kpc_s1;
        end
    end

    function automatic logic [3:0] key_lut(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] k;
        k = 4'h0;
        case ({row, col})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Exactly one low row and exactly one low column decode to a key
    always_comb begin
        row_idx = 2'd0;
        row_ok  = 1'b1;
        case (kpr_s2)
            4'b0111: row_idx = 2'd0;
            4'b1011: row_idx = 2'd1;
            4'b1101: row_idx = 2'd2;
            4'b1110: row_idx = 2'd3;
            default: row_ok  = 1'b0;
        endcase
        col_idx = 2'd0;
        col_ok  = 1'b1;
        case (kpc_s2)
            4'b0111: col_idx = 2'd0;
            4'b1011: col_idx = 2'd1;
            4'b1101: col_idx = 2'd2;
            4'b1110: col_idx = 2'd3;
            default: col_ok  = 1'b0;
        endcase
        dec_valid = row_ok & col_ok;
        dec_key   = key_lut(row_idx, col_idx);
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= 4'h0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KPD_REPEAT_EN
            rpt       <= '0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cand      <= cand_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            key_held  <= held_nxt;
`ifdef KPD_REPEAT_EN
            rpt       <= rpt_nxt;
`endif
        end
    end

    // A press is accepted only from IDLE, so a new key always needs a debounced release first
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        code_nxt  = key_code;
        valid_nxt = 1'b0;
        held_nxt  = key_held;
`ifdef KPD_REPEAT_EN
        rpt_nxt   = '0;
`endif
        case (state)
            IDLE: begin
                if (dec_valid) begin
                    cand_nxt  = dec_key;
                    cnt_nxt   = CNT_ONE;
                    state_nxt = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!dec_valid) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (dec_key != cand) begin
                    cand_nxt = dec_key;
                    cnt_nxt  = CNT_ONE;
                end else if (cnt == CNT_MAX) begin
                    code_nxt  = cand;
                    valid_nxt = 1'b1;
                    held_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = PRESSED;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            PRESSED: begin
                if (!dec_valid) begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = RELEASE_DB;
                end
`ifdef KPD_REPEAT_EN
                else if (dec_key == key_code) begin
                    if (rpt == RPT_LAST) begin
                        valid_nxt = 1'b1;
                    end else begin
                        rpt_nxt = rpt + RPT_W'(1);
                    end
                end
`endif
            end
            RELEASE_DB: begin
                if (dec_valid) begin
                    cnt_nxt   = '0;
                    state_nxt = PRESSED;
                end else if (cnt == CNT_MAX) begin
                    held_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_kpd_decoder.sv
// Directed bench for kpd_decoder with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.
// A press driven before step 1 is expected to strobe after step 7 (two sync stages plus four debounce samples).
module tb_kpd_decoder;

    localparam logic [15:0] DB = 16'd4;
    localparam logic [31:0] RP = 32'd10;
`ifdef KPD_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] kpc;
    logic [3:0] kpr;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    kpd_decoder #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_CYCLES  (RP)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .kpc      (kpc),
        .kpr      (kpr),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        kpc = 4'hF;
        kpr = 4'hF;
        repeat (n) step();
    endtask

    // Strobe at acceptance (step 7) and, with auto-repeat, every 10 steps after
    function automatic bit exp_strobe(input int k);
        return (k == 7) || (REPEAT && k > 7 && ((k - 7) % 10) == 0);
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        kpc = 4'hE;
        kpr = 4'hE;
        repeat (3) step();
        n_cmp++; if (key_code !== 4'h0) begin n_err++; $display("FAIL reset_code got %h expected 0", key_code); end
        n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b expected 0", key_valid); end
        n_cmp++; if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_held got %b expected 0", key_held); end
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_cmp++;
            if (key_valid !== exp_strobe(k)) begin
                n_err++; $display("FAIL reset_strobe k=%0d got %b expected %b", k, key_valid, exp_strobe(k));
            end
        end
        n_cmp++; if (key_code !== 4'hD) begin n_err++; $display("FAIL reset_after_code got %h expected d", key_code); end
        n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL reset_after_held got %b expected 1", key_held); end
        kpr = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_held !== (k < 7)) begin
                n_err++; $display("FAIL reset_release_held k=%0d got %b expected %b", k, key_held, (k < 7));
            end
        end
    endtask

    task automatic test_reset_mid();
        kpc = 4'hB;
        kpr = 4'hB;
        repeat (4) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        n_cmp++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin
            n_err++; $display("FAIL midreset_outputs got valid=%b held=%b expected 0 0", key_valid, key_held);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_valid !== (k == 7)) begin
                n_err++; $display("FAIL midreset_strobe k=%0d got %b expected %b", k, key_valid, (k == 7));
            end
        end
        kpr = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_held !== (k < 7)) begin
                n_err++; $display("FAIL midreset_release_held k=%0d got %b expected %b", k, key_held, (k < 7));
            end
        end
    endtask

    task automatic test_clean_press();
        kpc = 4'hB;
        kpr = 4'hB;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++;
            if (key_valid !== exp_strobe(k)) begin
                n_err++; $display("FAIL press5_strobe k=%0d got %b expected %b", k, key_valid, exp_strobe(k));
            end
            if (k == 7) begin
                n_cmp++; if (key_code !== 4'h5) begin n_err++; $display("FAIL press5_code got %h expected 5", key_code); end
                n_cmp++; if (key_held !== 1'b1) begin n_err++; $display("FAIL press5_held got %b expected 1", key_held); end
            end
        end
        kpr = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_held !== (k < 7)) begin
                n_err++; $display("FAIL press5_release_held k=%0d got %b expected %b", k, key_held, (k < 7));
            end
            n_cmp++;
            if (key_valid !== 1'b0) begin
                n_err++; $display("FAIL press5_release_strobe k=%0d got %b expected 0", k, key_valid);
            end
        end
    endtask

    task automatic test_bounce();
        kpc = 4'h7;
        for (int j = 0; j < 12; j++) begin
            kpr = ((j % 4) < 2) ? 4'h7 : 4'hF;
            step();
            n_cmp++;
            if (key_valid !== 1'b0) begin
                n_err++; $display("FAIL bounce_early_strobe j=%0d got %b expected 0", j, key_valid);
            end
        end
        kpr = 4'h7;
        for (int k = 1; k <= 9; k++) begin
            step();
            n_cmp++;
            if (key_valid !== (k == 7)) begin
                n_err++; $display("FAIL bounce_strobe k=%0d got %b expected %b", k, key_valid, (k == 7));
            end
        end
        n_cmp++; if (key_code !== 4'h1) begin n_err++; $display("FAIL bounce_code got %h expected 1", key_code); end
        kpr = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_held !== (k < 7)) begin
                n_err++; $display("FAIL bounce_release_held k=%0d got %b expected %b", k, key_held, (k < 7));
            end
        end
    endtask

    task automatic test_invalid();
        kpc = 4'hB;
        kpr = 4'h3;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++;
            if (key_valid !== 1'b0 || key_held !== 1'b0) begin
                n_err++; $display("FAIL two_rows k=%0d got valid=%b held=%b expected 0 0", k, key_valid, key_held);
            end
        end
        kpc = 4'h3;
        kpr = 4'hB;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++;
            if (key_valid !== 1'b0 || key_held !== 1'b0) begin
                n_err++; $display("FAIL two_cols k=%0d got valid=%b held=%b expected 0 0", k, key_valid, key_held);
            end
        end
        kpc = 4'hB;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_valid !== (k == 7)) begin
                n_err++; $display("FAIL after_invalid_strobe k=%0d got %b expected %b", k, key_valid, (k == 7));
            end
        end
        n_cmp++; if (key_code !== 4'h5) begin n_err++; $display("FAIL after_invalid_code got %h expected 5", key_code); end
        kpr = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_held !== (k < 7)) begin
                n_err++; $display("FAIL after_invalid_release k=%0d got %b expected %b", k, key_held, (k < 7));
            end
        end
    endtask

    task automatic test_release_glitch();
        kpc = 4'hD;
        kpr = 4'hE;
        for (int k = 1; k <= 10; k++) begin
            step();
            n_cmp++;
            if (key_valid !== exp_strobe(k)) begin
                n_err++; $display("FAIL hash_strobe k=%0d got %b expected %b", k, key_valid, exp_strobe(k));
            end
        end
        n_cmp++; if (key_code !== 4'hF) begin n_err++; $display("FAIL hash_code got %h expected f", key_code); end
        kpr = 4'hF;
        repeat (2) step();
        kpr = 4'hE;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_held !== 1'b1 || key_valid !== 1'b0) begin
                n_err++; $display("FAIL glitch k=%0d got held=%b valid=%b expected 1 0", k, key_held, key_valid);
            end
        end
        n_cmp++; if (key_code !== 4'hF) begin n_err++; $display("FAIL glitch_code got %h expected f", key_code); end
        kpr = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_held !== (k < 7)) begin
                n_err++; $display("FAIL glitch_release_held k=%0d got %b expected %b", k, key_held, (k < 7));
            end
        end
    endtask

    task automatic test_back_to_back();
        kpc = 4'hE;
        kpr = 4'hE;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_valid !== exp_strobe(k)) begin
                n_err++; $display("FAIL b2b_first_strobe k=%0d got %b expected %b", k, key_valid, exp_strobe(k));
            end
        end
        kpc = 4'hB;
        kpr = 4'hB;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if (key_valid !== 1'b0 || key_held !== 1'b1 || key_code !== 4'hD) begin
                n_err++; $display("FAIL b2b_switch k=%0d got valid=%b held=%b code=%h expected 0 1 d",
                                  k, key_valid, key_held, key_code);
            end
        end
        kpr = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_held !== (k < 7)) begin
                n_err++; $display("FAIL b2b_release_held k=%0d got %b expected %b", k, key_held, (k < 7));
            end
        end
        kpr = 4'hB;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_valid !== (k == 7)) begin
                n_err++; $display("FAIL b2b_second_strobe k=%0d got %b expected %b", k, key_valid, (k == 7));
            end
        end
        n_cmp++; if (key_code !== 4'h5) begin n_err++; $display("FAIL b2b_second_code got %h expected 5", key_code); end
        kpr = 4'hF;
        repeat (8) step();
    endtask

    task automatic test_repeat();
        int strobes;
        int exp_n;
        strobes = 0;
        exp_n   = REPEAT ? 4 : 1;
        kpc = 4'hE;
        kpr = 4'hE;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (key_valid === 1'b1) strobes++;
            n_cmp++;
            if (key_valid !== exp_strobe(k)) begin
                n_err++; $display("FAIL repeat_strobe k=%0d got %b expected %b", k, key_valid, exp_strobe(k));
            end
            if (k >= 7) begin
                n_cmp++;
                if (key_code !== 4'hD) begin
                    n_err++; $display("FAIL repeat_code k=%0d got %h expected d", k, key_code);
                end
            end
        end
        n_cmp++;
        if (strobes !== exp_n) begin
            n_err++; $display("FAIL repeat_count got %0d expected %0d", strobes, exp_n);
        end
        kpr = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_cmp++;
            if (key_held !== (k < 7)) begin
                n_err++; $display("FAIL repeat_release_held k=%0d got %b expected %b", k, key_held, (k < 7));
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        kpc = 4'hF;
        kpr = 4'hF;
        test_reset();
        idle(3);
        test_reset_mid();
        idle(3);
        test_clean_press();
        idle(3);
        test_bounce();
        idle(3);
        test_invalid();
        idle(3);
        test_release_glitch();
        idle(3);
        test_back_to_back();
        idle(3);
        test_repeat();
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
